// File: rtl/bfp_vector_multiply.sv
// Block-floating-point vector multiplier: per-lane mantissa products sharing one
// exponent, renormalised by a common block shift through a 3-stage stallable pipeline.
module bfp_vector_multiply #(
    parameter int unsigned LANES        = 4,
    parameter int unsigned FractionSize = 11,
    parameter int unsigned ExpSize      = 5,
    parameter int unsigned BIAS         = 2**(ExpSize-1)-1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [LANES*FractionSize-1:0]   factor1,
    input  logic [LANES*FractionSize-1:0]   factor2,
    input  logic [ExpSize-1:0]              exp1,
    input  logic [ExpSize-1:0]              exp2,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [LANES*FractionSize-1:0]   product,
    output logic [ExpSize-1:0]              exp_out,
    output logic                            overflow,
    output logic                            underflow
);

    localparam int unsigned PW  = 2*FractionSize;
    localparam int unsigned EW  = ExpSize + 2;
    // One extra bit so e + sh can never wrap before the saturation test.
    localparam int unsigned RW  = ExpSize + 3;
    localparam int unsigned LZW = $clog2(PW + 1);

    logic                               stall_c;
    logic                               v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [LANES-1:0][PW-1:0]           p1_q, p1_d, p2_q, p2_d;
    logic [EW-1:0]                      e1_q, e1_d, e2_q, e2_d;
    logic [PW-1:0]                      or_c, or2_q, or2_d;
    logic [LZW-1:0]                     lz_c, lz2_q, lz2_d, sh_c;
    logic [RW-1:0]                      r_c;
    logic [LANES-1:0][FractionSize-1:0] prod_q, prod_d;
    logic [ExpSize-1:0]                 exp_q, exp_d;
    logic                               ovf_q, ovf_d, udf_q, udf_d;

    assign stall_c  = v3_q & ~out_ready;
    assign in_ready = ~stall_c;

    assign out_valid = v3_q;
    assign product   = prod_q;
    assign exp_out   = exp_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

    // S1: raw lane products and biased exponent sum
    always_comb begin
        v1_d = v1_q;
        p1_d = p1_q;
        e1_d = e1_q;
        if (!stall_c) begin
            v1_d = in_valid;
            for (int i = 0; i < LANES; i++) begin
                p1_d[i] = PW'(factor1[i*FractionSize +: FractionSize])
                        * PW'(factor2[i*FractionSize +: FractionSize]);
            end
            e1_d = EW'(exp1) + EW'(exp2) - EW'(BIAS);
        end
    end

    // S2: block-wide leading-zero count over the OR of all lane products
    always_comb begin
        or_c = '0;
        for (int i = 0; i < LANES; i++) begin
            or_c = or_c | p1_q[i];
        end
        lz_c = LZW'(PW);
        for (int b = 0; b < PW; b++) begin
            if (or_c[b]) lz_c = LZW'(PW - 1 - b);
        end
    end

    always_comb begin
        v2_d  = v2_q;
        p2_d  = p2_q;
        e2_d  = e2_q;
        or2_d = or2_q;
        lz2_d = lz2_q;
        if (!stall_c) begin
            v2_d  = v1_q;
            p2_d  = p1_q;
            e2_d  = e1_q;
            or2_d = or_c;
            lz2_d = lz_c;
        end
    end

    // S3: common shift, exponent adjust and saturation
    always_comb begin
        sh_c = (lz2_q >= LZW'(FractionSize)) ? '0 : LZW'(FractionSize) - lz2_q;
        r_c  = {e2_q[EW-1], e2_q} + RW'(sh_c);
    end

    always_comb begin
        v3_d   = v3_q;
        prod_d = prod_q;
        exp_d  = exp_q;
        ovf_d  = ovf_q;
        udf_d  = udf_q;
        if (!stall_c) begin
            v3_d = v2_q;
            if (v2_q) begin
                prod_d = '0;
                exp_d  = '0;
                ovf_d  = 1'b0;
                udf_d  = 1'b0;
                if (or2_q != '0) begin
                    if (!r_c[RW-1] && (|r_c[RW-2:ExpSize])) begin
                        prod_d = '1;
                        exp_d  = '1;
                        ovf_d  = 1'b1;
                    end else if (r_c[RW-1]) begin
                        udf_d = 1'b1;
                    end else begin
                        exp_d = r_c[ExpSize-1:0];
                        for (int i = 0; i < LANES; i++) begin
                            prod_d[i] = FractionSize'(p2_q[i] >> sh_c);
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            p1_q   <= '0;
            p2_q   <= '0;
            e1_q   <= '0;
            e2_q   <= '0;
            or2_q  <= '0;
            lz2_q  <= '0;
            prod_q <= '0;
            exp_q  <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            v3_q   <= v3_d;
            p1_q   <= p1_d;
            p2_q   <= p2_d;
            e1_q   <= e1_d;
            e2_q   <= e2_d;
            or2_q  <= or2_d;
            lz2_q  <= lz2_d;
            prod_q <= prod_d;
            exp_q  <= exp_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
        end
    end

endmodule

// File: tb/tb_bfp_vector_multiply.sv
// Bench for bfp_vector_multiply: directed table, stall/reset sequences and a
// randomized stream scored against an arithmetic reference model.
module tb_bfp_vector_multiply;

    localparam int L = 4;
    localparam int F = 11;
    localparam int E = 5;
    localparam int W = L*F;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] factor1, factor2, product;
    logic [E-1:0] exp1, exp2, exp_out;
    logic         overflow, underflow;

    bfp_vector_multiply dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .factor1(factor1), .factor2(factor2), .exp1(exp1), .exp2(exp2),
        .out_valid(out_valid), .out_ready(out_ready), .product(product),
        .exp_out(exp_out), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] prod;
        logic [E-1:0] eo;
        logic         ovf;
        logic         udf;
    } res_t;

    typedef struct packed {
        logic [W-1:0] f1;
        logic [W-1:0] f2;
        logic [E-1:0] e1;
        logic [E-1:0] e2;
        res_t         exp;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   nout   = 0;
    res_t sb[$];
    logic held = 1'b0;
    res_t saved;

    // Reference: shift the block so its largest product fits F bits, then saturate.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [E-1:0] x, input logic [E-1:0] y);
        longint p[L];
        longint mx = 0;
        int bl, sh, r;
        res_t o;
        o = '0;
        for (int i = 0; i < L; i++) begin
            p[i] = longint'(a[i*F +: F]) * longint'(b[i*F +: F]);
            if (p[i] > mx) mx = p[i];
        end
        if (mx == 0) return o;
        bl = 0;
        while ((mx >> bl) != 0) bl++;
        sh = (bl > F) ? bl - F : 0;
        r  = int'(x) + int'(y) - 15 + sh;
        if (r > 31) begin
            o.prod = '1; o.eo = '1; o.ovf = 1'b1;
        end else if (r < 0) begin
            o.udf = 1'b1;
        end else begin
            o.eo = E'(r);
            for (int i = 0; i < L; i++) o.prod[i*F +: F] = F'(p[i] >> sh);
        end
        return o;
    endfunction

    function automatic logic [W-1:0] splat(input int v);
        logic [W-1:0] r;
        for (int i = 0; i < L; i++) r[i*F +: F] = F'(v);
        return r;
    endfunction

    function automatic res_t cur();
        res_t r;
        r.prod = product; r.eo = exp_out; r.ovf = overflow; r.udf = underflow;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic chk_res(input string name, input res_t act, input res_t req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual prod=%h exp=%0d ovf=%b udf=%b required prod=%h exp=%0d ovf=%b udf=%b",
                     name, act.prod, act.eo, act.ovf, act.udf, req.prod, req.eo, req.ovf, req.udf);
        end
    endtask

    // One cycle: drive at negedge, observe #1 later, transfers land on the next posedge.
    task automatic cyc(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [E-1:0] x, input logic [E-1:0] y, input logic ordy,
                       output logic fired);
        res_t exp_r;
        @(negedge clk);
        in_valid = iv; factor1 = a; factor2 = b; exp1 = x; exp2 = y; out_ready = ordy;
        #1;
        if (held) chk_res("hold_stable", cur(), saved);
        if (out_valid && out_ready) begin
            nout++;
            if (sb.size() == 0) begin
                chk("unexpected_out", 64'(out_valid), 64'(0));
            end else begin
                exp_r = sb.pop_front();
                chk_res("stream_result", cur(), exp_r);
            end
        end
        fired = in_valid && in_ready;
        if (fired) sb.push_back(model(a, b, x, y));
        held  = out_valid && !out_ready;
        saved = cur();
    endtask

    vec_t tbl[9];

    initial begin
        logic   f;
        int     n, k, n0;
        logic [W-1:0] a, b;
        logic [W-1:0] bf1[6];

        tbl[0] = '{splat(1024), splat(1024), 5'd15, 5'd15, '{splat(1024), 5'd25, 1'b0, 1'b0}};
        tbl[1] = '{splat(1024), splat(1024), 5'd31, 5'd31, '{splat(2047), 5'd31, 1'b1, 1'b0}};
        tbl[2] = '{splat(1),    splat(1),    5'd0,  5'd0,  '{splat(0),    5'd0,  1'b0, 1'b1}};
        tbl[3] = '{splat(0),    splat(1024), 5'd20, 5'd20, '{splat(0),    5'd0,  1'b0, 1'b0}};
        tbl[4] = '{{11'd0, 11'd100, 11'd1, 11'd2047}, {11'd0, 11'd100, 11'd1, 11'd2047},
                   5'd16, 5'd14, '{{11'd0, 11'd4, 11'd0, 11'd2046}, 5'd26, 1'b0, 1'b0}};
        tbl[5] = '{{11'd4, 11'd3, 11'd2, 11'd1}, splat(3), 5'd10, 5'd10,
                   '{{11'd12, 11'd9, 11'd6, 11'd3}, 5'd5, 1'b0, 1'b0}};
        tbl[6] = '{splat(1024), splat(1024), 5'd0,  5'd5,  '{splat(1024), 5'd0,  1'b0, 1'b0}};
        tbl[7] = '{splat(1024), splat(1024), 5'd18, 5'd18, '{splat(1024), 5'd31, 1'b0, 1'b0}};
        tbl[8] = '{splat(1024), splat(1024), 5'd18, 5'd19, '{splat(2047), 5'd31, 1'b1, 1'b0}};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        factor1 = '0; factor2 = '0; exp1 = '0; exp2 = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready",  64'(in_ready),  64'(1));
        chk_res("rst_outputs", cur(), '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table: one block at a time, latency and values
        for (int v = 0; v < 9; v++) begin
            @(negedge clk);
            in_valid = 1'b1; factor1 = tbl[v].f1; factor2 = tbl[v].f2;
            exp1 = tbl[v].e1; exp2 = tbl[v].e2; out_ready = 1'b1;
            #1;
            chk("tbl_in_ready", 64'(in_ready), 64'(1));
            n = 0;
            for (int c = 1; c <= 8; c++) begin
                @(negedge clk);
                in_valid = 1'b0;
                #1;
                if (out_valid) begin n = c; break; end
            end
            if (n == 0) begin
                chk("tbl_timeout", 64'(out_valid), 64'(1));
            end else begin
                chk("tbl_latency", 64'(n), 64'(3));
                chk_res($sformatf("tbl_vec%0d", v), cur(), tbl[v].exp);
            end
        end
        repeat (2) @(negedge clk);

        // Six distinct blocks streamed with a 5-cycle downstream stall
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < L; j++) bf1[i][j*F +: F] = F'(100*(i+1) + 37*j);
        end
        k = 0; n0 = nout; held = 1'b0;
        for (int t = 0; t < 40; t++) begin
            a = (k < 6) ? bf1[k] : '0;
            cyc(k < 6, a, splat(37 + k), E'(10 + k), 5'd12, !(t >= 4 && t < 9), f);
            if (t >= 4 && t < 9) begin
                chk("stall_out_valid", 64'(out_valid), 64'(1));
                chk("stall_in_ready",  64'(in_ready),  64'(0));
            end
            if (f) k++;
        end
        chk("stall_outputs_seen", 64'(nout - n0), 64'(6));
        chk("stall_sb_empty", 64'(sb.size()), 64'(0));

        // Reset with three blocks in flight
        for (int i = 0; i < 3; i++) cyc(1'b1, splat(500 + i), splat(700), 5'd14, 5'd15, 1'b0, f);
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        @(negedge clk);
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk_res("midrst_outputs", cur(), '0);
        chk("midrst_in_ready", 64'(in_ready), 64'(1));
        rst_n = 1'b1;
        sb.delete();
        held = 1'b0;
        for (int t = 0; t < 8; t++) begin
            cyc(1'b0, '0, '0, '0, '0, 1'b1, f);
            chk("no_stale_block", 64'(out_valid), 64'(0));
        end

        // Randomized stream with random backpressure
        for (int t = 0; t < 400; t++) begin
            for (int j = 0; j < L; j++) begin
                a[j*F +: F] = ($urandom_range(0, 3) == 0) ? F'($urandom_range(0, 15)) : F'($urandom_range(0, 2047));
                b[j*F +: F] = ($urandom_range(0, 3) == 0) ? F'($urandom_range(0, 15)) : F'($urandom_range(0, 2047));
            end
            if ($urandom_range(0, 9) == 0) a = '0;
            cyc($urandom_range(0, 9) < 7, a, b, E'($urandom_range(0, 31)), E'($urandom_range(0, 31)),
                $urandom_range(0, 9) < 7, f);
        end
        for (int t = 0; t < 10; t++) cyc(1'b0, '0, '0, '0, '0, 1'b1, f);
        chk("final_sb_empty", 64'(sb.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bfp_vector_multiply.md
BFP_VECTOR_MULTIPLY -- requirements
Module: bfp_vector_multiply

Interface
REQ-001 SHALL have parameter LANES, default 4: mantissa lanes per block.
REQ-002 SHALL have parameter FractionSize, default 11: unsigned mantissa width per lane.
REQ-003 SHALL have parameter ExpSize, default 5: unsigned biased shared-exponent width.
REQ-004 SHALL have parameter BIAS, default 2**(ExpSize-1)-1: exponent bias (15 at defaults).
REQ-005 SHALL use one clock and a synchronous, active-low reset.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst_n  input  1  synchronous active-low reset.
REQ-008 in_valid  input  1  input block present.
REQ-009 in_ready  output  1  block accepts input this cycle.
REQ-010 factor1, factor2  input  LANES*FractionSize each  lane i at bits [i*FractionSize +: FractionSize].
REQ-011 exp1, exp2  input  ExpSize each  shared exponents of factor1 and factor2 blocks.
REQ-012 out_valid  output  1  result block present.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 product  output  LANES*FractionSize  normalised result mantissas, same lane packing.
REQ-015 exp_out  output  ExpSize  shared result exponent.
REQ-016 overflow, underflow  output  1 each  saturation flags, qualified by out_valid.

Function
REQ-017 Input transfer occurs on a cycle with in_valid && in_ready; output transfer on out_valid && out_ready.
REQ-018 Three-stage pipeline: S1 registers raw lane products p_i = factor1_i*factor2_i (2*FractionSize bits, no truncation) and signed sum e = exp1+exp2-BIAS (ExpSize+2 bits); S2 registers OR-reduction of all p_i and its leading-zero count lz; S3 registers shifted, saturated outputs.
REQ-019 Latency 3 cycles from input transfer to out_valid when not stalled; throughput one block per cycle.
REQ-020 Stall: stall = out_valid && !out_ready; when stall all three stages hold contents and valids; in_ready = !stall (combinational).
REQ-021 Valid bubbles SHALL propagate; a stage without valid data never raises out_valid.
REQ-022 Block shift sh = max(0, FractionSize - lz), lz counted over 2*FractionSize bits; every lane product_i = p_i >> sh (truncate, no rounding); same sh for all lanes.
REQ-023 Unsaturated exponent r = e + sh, computed signed, ExpSize+2 bits, no wrap.
REQ-024 If r > 2**ExpSize-1: exp_out = all ones, every product lane = all ones, overflow = 1, underflow = 0.
REQ-025 If r < 0 and any p_i nonzero: exp_out = 0, every product lane = 0, underflow = 1, overflow = 0.
REQ-026 If all p_i are zero: product = 0, exp_out = 0, both flags 0, regardless of exponents.
REQ-027 Otherwise exp_out = r[ExpSize-1:0], flags 0.
REQ-028 Outputs SHALL be stable while out_valid && !out_ready.
REQ-029 Simultaneous input and output transfer in one cycle SHALL both complete, no loss or duplication; order preserved.

Reset
REQ-030 While rst_n = 0 at a clock edge: all stage valids cleared, out_valid = 0, product = 0, exp_out = 0, overflow = 0, underflow = 0.
REQ-031 in_ready = 1 after reset (no stall possible with out_valid = 0).
REQ-032 Reset mid-operation discards all in-flight blocks; none emerges after rst_n returns high.

Verification (defaults, BIAS=15)
REQ-033 All lanes factor1=factor2=1024, exp1=exp2=15, out_ready=1 -> 3 cycles later product lanes=1024, exp_out=25, flags 0.
REQ-034 Same mantissas, exp1=exp2=31 -> product lanes=2047, exp_out=31, overflow=1.
REQ-035 Lanes factor1=factor2=1, exp1=exp2=0 -> product=0, exp_out=0, underflow=1.
REQ-036 factor1 all 0, exp1=exp2=20 -> product=0, exp_out=0, flags 0.
REQ-037 Stream 6 distinct blocks back-to-back, out_ready low 5 cycles mid-stream -> in_ready low during stall, all 6 results in order, none lost or duplicated, outputs held stable.
REQ-038 Assert rst_n=0 one cycle with 3 blocks in flight -> out_valid=0 next cycle and no stale block appears afterwards.
